// File: rtl/upload_frame_parser_pkg.sv
// Shared definitions for the upload framing protocol: sync bytes, frame
// length, parser state encoding and a saturating counter helper.
package upload_frame_parser_pkg;

   localparam logic [7:0] SYNC0     = 8'h55;
   localparam logic [7:0] SYNC1     = 8'hAA;
   localparam int         FRAME_LEN = 6;

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_SYNC1 = 3'd1,
      ST_CMD   = 3'd2,
      ST_D1    = 3'd3,
      ST_D2    = 3'd4,
      ST_CHK   = 3'd5
   } state_t;

   // Increment that sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/upload_frame_parser_gap_timer.sv
// Inter-byte timeout: counts enabled cycles and pulses expire on the
// GAP_CYCLES-th consecutive enabled cycle. clear has priority over enable.
module frame_gap_timer #(
   parameter int GAP_CYCLES = 40
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int            CW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(GAP_CYCLES - 1);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   // Fires combinationally on the last allowed idle cycle so the parser can
   // leave the frame on the same edge; a clear in that cycle suppresses it.
   assign expire = enable && !clear && (count_reg == LAST);

   // Next count: restart on clear or expiry, otherwise advance while enabled.
   always_comb begin
      count_next = count_reg;
      if (clear || expire) begin
         count_next = '0;
      end else if (enable) begin
         count_next = count_reg + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/upload_frame_parser.sv
// Byte-stream parser for 6-byte upload frames (55 AA cmd d1 d2 chk).
// Publishes good frames with a one-cycle frame_valid pulse, flags checksum
// and inter-byte timeout errors, and keeps good/error frame counters.
module upload_frame_parser
   import upload_frame_parser_pkg::*;
#(
   parameter int GAP_CYCLES = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       frame_valid,
   output logic [7:0] frame_cmd,
   output logic [7:0] frame_data1,
   output logic [7:0] frame_data2,
   output logic       chk_err,
   output logic       gap_err,
   output logic [7:0] good_cnt,
   output logic [7:0] err_cnt
);

   state_t     state_reg;
   state_t     state_next;

   logic [7:0] cmd_reg, cmd_next;
   logic [7:0] data1_reg, data1_next;
   logic [7:0] data2_reg, data2_next;
   logic [7:0] sum_reg, sum_next;

   logic       frame_valid_next;
   logic       chk_err_next;
   logic       gap_err_next;

   logic       gap_clear;
   logic       gap_enable;
   logic       gap_expire;

   // The gap timer only runs while a frame is in progress and idle.
   assign gap_enable = (state_reg != ST_HUNT) && !rx_valid;
   assign gap_clear  = rx_valid || (state_reg == ST_HUNT);

   frame_gap_timer #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_gap_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (gap_clear),
      .enable (gap_enable),
      .expire (gap_expire)
   );

   // Next-state, staging capture, running checksum and pulse decisions.
   always_comb begin
      state_next       = state_reg;
      cmd_next         = cmd_reg;
      data1_next       = data1_reg;
      data2_next       = data2_reg;
      sum_next         = sum_reg;
      frame_valid_next = 1'b0;
      chk_err_next     = 1'b0;
      gap_err_next     = 1'b0;

      if (rx_valid) begin
         case (state_reg)
            ST_HUNT: begin
               if (rx_byte == SYNC0) state_next = ST_SYNC1;
            end
            ST_SYNC1: begin
               if (rx_byte == SYNC1) begin
                  state_next = ST_CMD;
               end else if (rx_byte == SYNC0) begin
                  state_next = ST_SYNC1;
               end else begin
                  state_next = ST_HUNT;
               end
            end
            ST_CMD: begin
               cmd_next   = rx_byte;
               sum_next   = rx_byte;
               state_next = ST_D1;
            end
            ST_D1: begin
               data1_next = rx_byte;
               sum_next   = sum_reg + rx_byte;
               state_next = ST_D2;
            end
            ST_D2: begin
               data2_next = rx_byte;
               sum_next   = sum_reg + rx_byte;
               state_next = ST_CHK;
            end
            ST_CHK: begin
               if (rx_byte == sum_reg) begin
                  frame_valid_next = 1'b1;
               end else begin
                  chk_err_next = 1'b1;
               end
               state_next = ST_HUNT;
            end
            default: state_next = ST_HUNT;
         endcase
      end else if (gap_expire) begin
         // A byte in the expiry cycle never reaches here, so it wins.
         state_next   = ST_HUNT;
         gap_err_next = 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_HUNT;
      end else begin
         state_reg <= state_next;
      end
   end

   // Staging registers, published frame fields, pulses and counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_reg     <= 8'd0;
         data1_reg   <= 8'd0;
         data2_reg   <= 8'd0;
         sum_reg     <= 8'd0;
         frame_valid <= 1'b0;
         chk_err     <= 1'b0;
         gap_err     <= 1'b0;
         frame_cmd   <= 8'd0;
         frame_data1 <= 8'd0;
         frame_data2 <= 8'd0;
         good_cnt    <= 8'd0;
         err_cnt     <= 8'd0;
      end else begin
         cmd_reg     <= cmd_next;
         data1_reg   <= data1_next;
         data2_reg   <= data2_next;
         sum_reg     <= sum_next;
         frame_valid <= frame_valid_next;
         chk_err     <= chk_err_next;
         gap_err     <= gap_err_next;
         if (frame_valid_next) begin
            frame_cmd   <= cmd_reg;
            frame_data1 <= data1_reg;
            frame_data2 <= data2_reg;
            good_cnt    <= good_cnt + 8'd1;
         end
         if (chk_err_next || gap_err_next) begin
            err_cnt <= sat_inc8(err_cnt);
         end
      end
   end

endmodule
